ram_rw_port_arbiter: RTL
========================

Name: ram_rw_port_arbiter

Overview:
- Shares the single read-write port of the byte-addressed 128-bit composed RAM between two requesters: the CPU load/store unit (requester 0) and the HDMI/DMA fetch engine (requester 1).
- Arbitrates round-robin, issues at most one access per cycle and forwards the byte enables.
- Tracks in-flight reads through a fixed-latency tag pipeline and routes each response back to its issuer.
- Sits directly in front of the RAM wrapper; the wrapper's per-lane offset addressing is unchanged.

Parameters:
- ADDR_W, 19, byte address width of the RAM port
- DATA_W, 128, data width; byte lanes = DATA_W/8 = 16
- RD_LATENCY, 2, cycles from RAM address capture to valid ram_rdata (must be >=1)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  2  per-requester request valid, index = requester id
- req_ready  out  2  per-requester accept; a handshake occurs when valid&ready
- req_we  in  2  1 = write, 0 = read
- req_addr  in  2*ADDR_W  byte address, requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  2*DATA_W  write data
- req_be  in  2*16  byte enables (writes only; ignored for reads)
- rsp_valid  out  2  response valid pulse, one cycle, no backpressure
- rsp_rdata  out  DATA_W  read data (shared bus, qualified by rsp_valid)
- ram_addr  out  ADDR_W  to RAM rw port
- ram_we  out  1  RAM write strobe
- ram_be  out  16  RAM byte enables
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data
- busy  out  1  any access in flight

Behaviour:
- Reset (rst=1 at a clock edge):
  - req_ready=0, rsp_valid=0, ram_we=0, ram_be=0, ram_addr=0, ram_wdata=0, busy=0.
  - Last-grant pointer resets to 1, so requester 0 wins the first tie.
  - Tag pipeline is cleared; in-flight responses are dropped and never delivered.
- Arbitration is combinational within the cycle:
  - Only one valid: that requester is granted.
  - Both valid: the requester that is not the last-grant pointer wins.
  - req_ready is one-hot of the grant and is 0 for both when neither is valid.
  - req_ready never depends on rsp state; a new access issues every cycle.
- Issue: on a handshake, ram_addr/ram_we/ram_be/ram_wdata are registered from the winner. The RAM sees them the cycle after the handshake. The last-grant pointer updates to the winner.
- Idle cycle (no handshake): ram_we=0 and ram_be=0 are registered. ram_addr and ram_wdata hold their previous value.
- Write with req_be=0: issued as ram_we=1, ram_be=0 (a no-op on the RAM). It still receives an ack.
- Tag pipeline:
  - Depth RD_LATENCY+1 entries of {valid, id}, shifted every cycle.
  - Entry 0 is loaded on the handshake cycle.
  - Reads and writes both enter the pipeline.
- Response:
  - rsp_valid[id] is asserted exactly RD_LATENCY+1 cycles after the handshake edge.
  - rsp_rdata = ram_rdata for reads, and 0 for write acks.
  - Responses are delivered in issue order; ids are never reordered.
- Back-to-back operation:
  - Alternating grants give 1 access per cycle sustained.
  - One persistent requester alone gets 1 per cycle.
  - Under contention each requester gets every other cycle.
- Simultaneous events:
  - A handshake and a response delivery in the same cycle are independent.
  - Requests that are valid but not granted must hold stable; the arbiter does not latch them.
- busy = OR of the tag-pipeline valid bits, or of the current handshake.
- rst asserted mid-burst: the next cycle behaves as post-reset. A requester whose handshake coincided with rst is treated as not accepted.

Decomposition:
- Package ram_arb_pkg:
  - NUM_REQ=2, LANES=16.
  - typedef req_id_t (1 bit) with constants REQ_CPU=0 and REQ_DMA=1.
  - typedef tag_t struct {logic valid; req_id_t id; logic is_read;}.
- One sub-module, ram_rsp_tag_pipe:
  - Parameterized by RD_LATENCY.
  - Shift register of tag_t, plus a decode to rsp_valid and an rdata/zero mux.
- Arbitration and issue registers stay in the top module.

Test Plan:
- Reset then idle: rst for 3 cycles, all req_valid=0 → req_ready=00, ram_we=0, busy=0, rsp_valid=00 throughout.
- Single read: req0 read addr 0x00010, ram_rdata model returns 0xA5 repeated → ram_addr=0x00010 one cycle after the handshake; rsp_valid=01 exactly 3 cycles after the handshake (RD_LATENCY=2), with rsp_rdata=0xA5A5…A5.
- Contention:
  - Stimulus: both requesters valid for 6 cycles (req0 reads addr 0x100, req1 reads 0x200), starting from reset.
  - Grants: req_ready sequence 01,10,01,10,01,10.
  - Responses: rsp_valid has the same order, offset by 3 cycles.
- Write ack: req1 write addr 0x7FFFF (max address), be=0x8001, wdata=0x11..11 → ram_we=1, ram_be=0x8001, ram_addr=0x7FFFF; rsp_valid=10 with rsp_rdata=0 three cycles later.
- Reset mid-flight:
  - Stimulus: two reads issued on consecutive cycles, then rst pulsed one cycle later.
  - Response: no rsp_valid for either read; busy=0 the cycle after rst.
  - Follow-up: the next request from req1 alone is granted immediately.
- Persistent single requester: req0 valid for 8 cycles with incrementing addresses 0..7 → req_ready=01 each cycle; 8 consecutive rsp_valid=01 pulses carry data for addresses 0..7 in order.

Source files
------------

// File: rtl/ram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ram_arb_pkg
// Brief    : Shared types and constants for the RAM read-write port arbiter.
// Revision : 1.0
// ============================================================================
package ram_arb_pkg;

    localparam int NUM_REQ = 2;
    localparam int LANES   = 16;

    typedef logic [0:0] req_id_t;

    localparam req_id_t REQ_CPU = 1'b0;
    localparam req_id_t REQ_DMA = 1'b1;

    typedef struct packed {
        logic    valid;
        req_id_t id;
        logic    is_read;
    } tag_t;

    function automatic logic [NUM_REQ-1:0] id_to_onehot(input req_id_t id);
        logic [NUM_REQ-1:0] w_oh;
        w_oh     = '0;
        w_oh[id] = 1'b1;
        return w_oh;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ram_rsp_tag_pipe.sv
`default_nettype none
// ============================================================================
// Module   : ram_rsp_tag_pipe
// Brief    : Fixed-latency tag shift register that steers RAM responses back.
// Revision : 1.0
// ============================================================================
module ram_rsp_tag_pipe
    import ram_arb_pkg::*;
#(
    parameter int RD_LATENCY = 2,
    parameter int DATA_W     = 128
) (
    input  logic                clk,
    input  logic                rst,
    input  tag_t                i_tag,
    input  logic [DATA_W-1:0]   i_ram_rdata,
    output logic [NUM_REQ-1:0]  o_rsp_valid,
    output logic [DATA_W-1:0]   o_rsp_rdata,
    output logic                o_any_valid
);

    localparam int DEPTH = RD_LATENCY + 1;

    tag_t [DEPTH-1:0] r_tags;
    tag_t             w_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tags <= '0;
        end else begin
            r_tags <= {r_tags[DEPTH-2:0], i_tag};
        end
    end

    // The last stage lines up with the cycle the RAM presents read data.
    assign w_out       = r_tags[RD_LATENCY];
    assign o_rsp_valid = w_out.valid ? id_to_onehot(w_out.id) : '0;
    assign o_rsp_rdata = (w_out.valid && w_out.is_read) ? i_ram_rdata : '0;

    always_comb begin
        o_any_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            o_any_valid = o_any_valid | r_tags[i].valid;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ram_rw_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_rw_port_arbiter
// Brief    : Round-robin sharing of the 128-bit RAM rw port between CPU and DMA.
// Revision : 1.0
// ============================================================================
module ram_rw_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W     = 19,
    parameter int DATA_W     = 128,
    parameter int RD_LATENCY = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ-1:0]          req_we,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
    input  logic [NUM_REQ*LANES-1:0]    req_be,
    output logic [NUM_REQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]           rsp_rdata,
    output logic [ADDR_W-1:0]           ram_addr,
    output logic                        ram_we,
    output logic [LANES-1:0]            ram_be,
    output logic [DATA_W-1:0]           ram_wdata,
    input  logic [DATA_W-1:0]           ram_rdata,
    output logic                        busy
);

    req_id_t            r_last_grant;
    req_id_t            w_grant_id;
    logic               w_hs;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic [DATA_W-1:0]  w_sel_wdata;
    logic [LANES-1:0]   w_sel_be;
    logic               w_sel_we;
    logic               w_pipe_busy;
    tag_t               w_tag;

    logic [ADDR_W-1:0]  r_ram_addr;
    logic               r_ram_we;
    logic [LANES-1:0]   r_ram_be;
    logic [DATA_W-1:0]  r_ram_wdata;

    always_comb begin
        w_grant_id = REQ_CPU;
        case (req_valid)
            2'b01:   w_grant_id = REQ_CPU;
            2'b10:   w_grant_id = REQ_DMA;
            2'b11:   w_grant_id = ~r_last_grant;
            default: w_grant_id = REQ_CPU;
        endcase
    end

    // A request presented while rst is high is never accepted.
    assign w_hs      = (|req_valid) && !rst;
    assign req_ready = w_hs ? id_to_onehot(w_grant_id) : '0;

    assign w_sel_addr  = w_grant_id ? req_addr[ADDR_W +: ADDR_W]   : req_addr[0 +: ADDR_W];
    assign w_sel_wdata = w_grant_id ? req_wdata[DATA_W +: DATA_W]  : req_wdata[0 +: DATA_W];
    assign w_sel_be    = w_grant_id ? req_be[LANES +: LANES]       : req_be[0 +: LANES];
    assign w_sel_we    = req_we[w_grant_id];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= REQ_DMA;
            r_ram_addr   <= '0;
            r_ram_we     <= 1'b0;
            r_ram_be     <= '0;
            r_ram_wdata  <= '0;
        end else if (w_hs) begin
            r_last_grant <= w_grant_id;
            r_ram_addr   <= w_sel_addr;
            r_ram_we     <= w_sel_we;
            r_ram_be     <= w_sel_we ? w_sel_be : '0;
            r_ram_wdata  <= w_sel_wdata;
        end else begin
            r_ram_we     <= 1'b0;
            r_ram_be     <= '0;
        end
    end

    assign ram_addr  = r_ram_addr;
    assign ram_we    = r_ram_we;
    assign ram_be    = r_ram_be;
    assign ram_wdata = r_ram_wdata;

    assign w_tag = '{valid: w_hs, id: w_grant_id, is_read: ~w_sel_we};

    ram_rsp_tag_pipe #(
        .RD_LATENCY (RD_LATENCY),
        .DATA_W     (DATA_W)
    ) u_tag_pipe (
        .clk         (clk),
        .rst         (rst),
        .i_tag       (w_tag),
        .i_ram_rdata (ram_rdata),
        .o_rsp_valid (rsp_valid),
        .o_rsp_rdata (rsp_rdata),
        .o_any_valid (w_pipe_busy)
    );

    assign busy = w_pipe_busy | w_hs;

endmodule
`default_nettype wire
